// File: rtl/fmap_row_reader.sv
// Captures a full conv output map on start and streams it one row per valid/ready beat, row 0 first.
// Row 0 valid one edge after start; a row holds while row_ready=0; done pulses once after the final beat.
module fmap_row_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]           featureMap,
  input  logic                                            start,
  input  logic                                            row_ready,
  output logic [0:(W-F+1)*DATA_WIDTH-1]                   row,
  output logic                                            row_valid,
  output logic [5:0]                                      row_index,
  output logic                                            last,
  output logic                                            busy,
  output logic                                            done
);
  localparam int OUT_H = H - F + 1;
  localparam int OUT_W = W - F + 1;
  localparam int ROWW  = OUT_W * DATA_WIDTH;
  localparam int MAPW  = OUT_H * ROWW;
  localparam int BW    = $clog2(MAPW);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [0:MAPW-1]   buffer;
  logic [5:0]        idx_nxt;
  logic [BW-1:0]     base_nxt;
  logic              xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // row_valid is always 1 in STREAM, so a beat only needs row_ready
  always_comb begin
    state_nxt = state;
    xfer      = (state == S_STREAM) && row_ready;
    idx_nxt   = row_index + 6'd1;
    base_nxt  = BW'(idx_nxt) * BW'(ROWW);
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (xfer && last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer    <= '0;
      row       <= '0;
      row_valid <= 1'b0;
      row_index <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            buffer    <= featureMap;
            row       <= featureMap[0 +: ROWW];
            row_index <= '0;
            row_valid <= 1'b1;
            busy      <= 1'b1;
            last      <= (OUT_H == 1);
          end
        end
        S_STREAM: begin
          if (row_ready) begin
            if (last) begin
              row_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              last      <= 1'b0;
            end else begin
              row_index <= idx_nxt;
              row       <= buffer[base_nxt +: ROWW];
              last      <= (idx_nxt == 6'(OUT_H - 1));
            end
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          row_index <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fmap_row_reader.sv
// Directed table-driven bench for fmap_row_reader with hand sequences for reset corner cases.
module tb_fmap_row_reader;
  localparam int DW    = 32;
  localparam int OUT_H = 28;
  localparam int OUT_W = 28;
  localparam int ROWW  = OUT_W * DW;
  localparam int MAPW  = OUT_H * ROWW;

  typedef struct {
    logic       st;
    logic       rdy;
    logic [1:0] fsel;
    logic [1:0] esel;
    logic       vld;
    logic [5:0] idx;
    logic       lst;
    logic       bsy;
    logic       dn;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [0:MAPW-1] featureMap;
  logic            start;
  logic            row_ready;
  logic [0:ROWW-1] row;
  logic            row_valid;
  logic [5:0]      row_index;
  logic            last;
  logic            busy;
  logic            done;

  int n_chk = 0;
  int n_err = 0;
  int xfers = 0;
  int dones = 0;
  vec_t vecs[$];
  logic [0:MAPW-1] maps [4];
  logic [5:0] bp_pat = 6'b101001;

  fmap_row_reader dut (
    .clk(clk), .reset(reset), .featureMap(featureMap), .start(start),
    .row_ready(row_ready), .row(row), .row_valid(row_valid),
    .row_index(row_index), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [1:0] sel, input int r, input int c);
    case (sel)
      2'd0:    return DW'(r * 256 + c);
      2'd1:    return 32'hA500_0000 | DW'(c * 256 + r);
      2'd2:    return '1;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_row(input string nm, input logic [1:0] sel, input int r);
    int bad = -1;
    n_chk++;
    for (int c = 0; c < OUT_W; c++)
      if (bad < 0 && row[c*DW +: DW] !== word(sel, r, c)) bad = c;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s row=%0d word=%0d got=%h expected=%h", nm, r, bad,
               row[bad*DW +: DW], word(sel, r, bad));
    end
  endtask

  task automatic push(input logic st, input logic rdy, input logic [1:0] fsel, input logic [1:0] esel,
                      input logic vld, input int idx, input logic lst, input logic bsy, input logic dn);
    vec_t v;
    v.st = st; v.rdy = rdy; v.fsel = fsel; v.esel = esel;
    v.vld = vld; v.idx = 6'(idx); v.lst = lst; v.bsy = bsy; v.dn = dn;
    vecs.push_back(v);
  endtask

  // One frame: start beat (ready high, must be ignored), then beats until the final transfer.
  task automatic add_frame(input logic [1:0] msel, input logic [1:0] msel_after,
                           input bit bp, input bit restart);
    int idx = 0;
    logic rdy, sin;
    push(1'b1, 1'b1, msel, msel, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      rdy = bp ? bp_pat[k % 6] : 1'b1;
      sin = restart && (k == 10);
      if (rdy && idx == OUT_H - 1) begin
        push(sin, 1'b1, msel_after, msel, 1'b0, idx, 1'b0, 1'b0, 1'b1);
        break;
      end
      if (rdy) idx++;
      push(sin, rdy, msel_after, msel, 1'b1, idx, idx == OUT_H - 1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < OUT_H; r++)
        for (int c = 0; c < OUT_W; c++)
          maps[s][(r*OUT_W + c)*DW +: DW] = word(2'(s), r, c);

    for (int i = 0; i < 10; i++) push(1'b0, 1'(i % 2), 2'd0, 2'd0, 0, 0, 0, 0, 0);
    add_frame(2'd0, 2'd0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    add_frame(2'd1, 2'd1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'd1, 2'd1, 0, 0, 0, 0, 0);
    add_frame(2'd0, 2'd2, 1'b1, 1'b1);
    push(1'b0, 1'b1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
    add_frame(2'd1, 2'd1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    push(1'b1, 1'b0, 2'd0, 2'd0, 1, 0, 0, 1, 0);

    reset = 1'b0; start = 1'b0; row_ready = 1'b0; featureMap = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 16'({row_valid, row_index, last, busy, done}), 16'd0);
    n_chk++;
    if (row !== '0) begin
      n_err++;
      $display("FAIL reset_row got=%h expected=0", row[0 +: DW]);
    end
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].st; row_ready = vecs[i].rdy; featureMap = maps[vecs[i].fsel];
      if (row_valid && row_ready) xfers++;
      @(posedge clk);
      #1;
      if (done) dones++;
      chk($sformatf("vec%0d_ctrl", i), 16'({row_valid, row_index, last, busy, done}),
          16'({vecs[i].vld, vecs[i].idx, vecs[i].lst, vecs[i].bsy, vecs[i].dn}));
      if (vecs[i].vld) chk_row($sformatf("vec%0d_row", i), vecs[i].esel, int'(vecs[i].idx));
    end
    chk("transfer_count", 16'(xfers), 16'(4 * OUT_H));
    chk("done_count", 16'(dones), 16'd4);

    // Mid-stream reset at row 13 of the frame just started
    @(negedge clk);
    start = 1'b0; row_ready = 1'b1;
    repeat (13) @(negedge clk);
    chk("pre_reset_idx", 16'({row_valid, row_index, busy}), 16'({1'b1, 6'd13, 1'b1}));
    chk_row("pre_reset_row", 2'd0, 13);
    #2 reset = 1'b0; row_ready = 1'b0;
    #1;
    chk("async_reset", 16'({row_valid, row_index, last, busy, done}), 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1; featureMap = maps[1];
    @(posedge clk);
    #1;
    chk("restart_ctrl", 16'({row_valid, row_index, busy}), 16'({1'b1, 6'd0, 1'b1}));
    chk_row("restart_row0", 2'd1, 0);
    @(negedge clk);
    start = 1'b0; row_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_idx1", 16'({row_valid, row_index}), 16'({1'b1, 6'd1}));
    chk_row("restart_row1", 2'd1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fmap_row_reader.md
# fmap_row_reader

Reads a complete convolution output feature map (OUT_H × OUT_W words, OUT_H = H-F+1, OUT_W = W-F+1) and streams it out one row per handshake over a valid/ready interface, row 0 first. It is the read-side counterpart of the row-indexed feature-map assembly used at the convolution output. It feeds downstream row-serial consumers such as pooling and activation. On start, the map is captured into an internal buffer, so the upstream vector may change while streaming is in progress.

## Interface
- DATA_WIDTH, 32, bits per word
- H, 32, input image height
- W, 32, input image width
- F, 5, filter size; OUT_H = H-F+1, OUT_W = W-F+1; OUT_H ≤ 64 required
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- featureMap  input  [0:OUT_H*OUT_W*DATA_WIDTH-1]  full map; row r at offset r*OUT_W*DATA_WIDTH, word c of row at +c*DATA_WIDTH
- start  input  1  request to capture featureMap and stream it
- row_ready  input  1  consumer accepts the current row
- row  output  [0:OUT_W*DATA_WIDTH-1]  current row data
- row_valid  output  1  row/row_index/last are valid
- row_index  output  6  index of the current row (0..OUT_H-1)
- last  output  1  current row is row OUT_H-1
- busy  output  1  streaming in progress
- done  output  1  one-cycle pulse after the final row is accepted

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: if start=1 at a clock edge, capture featureMap into the buffer, set row_index=0, row_valid=1, busy=1, and go to STREAM. Otherwise hold all outputs at their idle values.
- STREAM:
  - row = buffer[row_index*OUT_W*DATA_WIDTH +: OUT_W*DATA_WIDTH]; last = (row_index == OUT_H-1).
  - Transfer occurs at an edge where row_valid=1 and row_ready=1.
  - Transfer with last=0: row_index increments by 1 and the next row is presented.
  - Transfer with last=1: row_valid=0, busy=0, done=1, next state DONE.
  - No transfer: row, row_index, last and row_valid hold unchanged. row_valid never drops before the transfer.
- DONE: lasts one cycle, then done=0 and next state IDLE; row_index returns to 0.
- start is ignored in STREAM and DONE. Changes to featureMap after capture have no effect until the next capture.
- row_index arithmetic is 6-bit unsigned and never wraps within a frame (terminates at OUT_H-1).
- row output in IDLE/DONE: the last buffered row is allowed, but is don't-care since row_valid=0. The bench checks row only when row_valid=1.

## Timing
- Reset (reset=0, asynchronous): state IDLE, row_valid=0, row_index=0, last=0, busy=0, done=0, row=0, buffer=0. Takes effect immediately and also applies mid-stream. The first edge with reset=1 starts from IDLE.
- Latency: start sampled at edge N → row 0 valid after edge N.
- Throughput: with row_ready held at 1, one row per cycle. Rows are accepted at edges N+1 … N+OUT_H. done is high for the cycle after edge N+OUT_H; IDLE follows after edge N+OUT_H+1.
- Earliest restart: start accepted at edge N+OUT_H+1, giving 1 dead cycle (DONE) between frames.
- All outputs are registered; no combinational path from row_ready or start to any output.
- start and row_ready high on the same edge in IDLE: start is acted on, and row_ready has no effect (no row is valid yet).

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release, start=0 for 10 cycles → all outputs 0 and busy never asserts.
- Full frame, ready always high: featureMap word (r,c) = r*256+c, pulse start.
  - Row r appears on consecutive cycles with row_index=r and word c = r*256+c.
  - last is high only with row_index=27.
  - done pulses exactly once, at the 29th cycle after start.
- Backpressure: ready pattern 1,0,0,1,0,1… → each row is held stable while not ready; no row is skipped or duplicated; 28 transfers total.
- Capture isolation: change featureMap to all 0xFFFFFFFF one cycle after start, and pulse start again mid-stream → streamed data still equals the original map, and only one done pulse occurs.
- Reset mid-stream: assert reset=0 at row_index=13 → row_valid=0 and busy=0 immediately. A new start after release streams from row_index 0.
- Back-to-back frames: a second start on the cycle done=1 is ignored; start on the following cycle is accepted, and row 0 of the new map appears one edge later.
